// File: rtl/seq_det_arbiter_pkg.sv
// seq_det_arbiter_pkg: shared defaults for the time-multiplexed pattern detector
package seq_det_arbiter_pkg;
  localparam int N_CH_DEF = 4;
  localparam int PAT_W_DEF = 6;
  localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 6'b110011;
  localparam int CNT_W = 16;
endpackage

// File: rtl/seq_det_arbiter_rr_arbiter.sv
// rr_arbiter: zero-latency round-robin grant, pointer advances past the winner
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] gnt
);
  logic [CH_W-1:0] ptr_q, ptr_d, idx;
  // search from ptr upward; lower offsets overwrite later so the nearest requester wins
  always_comb begin
    gnt = '0;
    ptr_d = ptr_q;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = CH_W'((int'(ptr_q) + i) % N_CH);
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
        ptr_d = (idx == CH_W'(N_CH - 1)) ? '0 : idx + 1'b1;
      end
    end
  end
  // pointer register
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter: shared serial pattern detector across round-robin-arbitrated channels
module seq_det_arbiter
  import seq_det_arbiter_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int PAT_W = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PATTERN_DEF),
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  req,
  input  logic [N_CH-1:0]  bit_in,
  input  logic [N_CH-1:0]  clr,
  output logic [N_CH-1:0]  gnt,
  output logic             match_valid,
  output logic [CH_W-1:0]  match_ch,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int FW = $clog2(PAT_W + 1);
  logic [PAT_W-1:0] hist_q [N_CH];
  logic [PAT_W-1:0] hist_d [N_CH];
  logic [FW-1:0]    fill_q [N_CH];
  logic [FW-1:0]    fill_d [N_CH];
  logic             hit, match_valid_q, match_valid_d;
  logic [CH_W-1:0]  hit_ch, match_ch_q, match_ch_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .gnt  (gnt)
  );
  // shift the granted bit into its channel, compare, and let a clear override both
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    hit = 1'b0;
    hit_ch = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (gnt[c]) begin
        hist_d[c] = {hist_q[c][PAT_W-2:0], bit_in[c]};
        fill_d[c] = (fill_q[c] == FW'(PAT_W)) ? fill_q[c] : fill_q[c] + 1'b1;
        hit = !clr[c] && hist_d[c] == PATTERN && fill_d[c] == FW'(PAT_W);
        hit_ch = CH_W'(c);
      end
      if (clr[c]) begin
        hist_d[c] = '0;
        fill_d[c] = '0;
      end
    end
    match_valid_d = hit;
    match_ch_d = hit ? hit_ch : match_ch_q;
    match_cnt_d = (hit && match_cnt_q != '1) ? match_cnt_q + 1'b1 : match_cnt_q;
  end
  // history bank and registered match outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        hist_q[c] <= '0;
        fill_q[c] <= '0;
      end
      match_valid_q <= 1'b0;
      match_ch_q <= '0;
      match_cnt_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      match_valid_q <= match_valid_d;
      match_ch_q <= match_ch_d;
      match_cnt_q <= match_cnt_d;
    end
  assign match_valid = match_valid_q;
  assign match_ch = match_ch_q;
  assign match_cnt = match_cnt_q;
endmodule

// File: tb/tb_seq_det_arbiter.sv
// tb_seq_det_arbiter: table-driven directed bench for seq_det_arbiter
module tb_seq_det_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req, bit_in, clr, gnt;
  logic match_valid;
  logic [1:0] match_ch;
  logic [15:0] match_cnt;
  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  bit_in;
    logic [3:0]  clr;
    logic [3:0]  gnt;
    logic        mv;
    logic [1:0]  mch;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs[$];

  seq_det_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .bit_in     (bit_in),
    .clr        (clr),
    .gnt        (gnt),
    .match_valid(match_valid),
    .match_ch   (match_ch),
    .match_cnt  (match_cnt)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic [3:0] r, b, c, g, input logic mv,
                              input logic [1:0] ch, input logic [15:0] cnt);
    vec_t v;
    v = '{r, b, c, g, mv, ch, cnt};
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
  endtask

  initial begin
    logic [9:0] p10;
    logic [5:0] p6;
    p10 = 10'b1100110011;
    p6 = 6'b110011;
    reset = 1'b1;
    req = 4'b1111;
    bit_in = '0;
    clr = '0;
    @(negedge clk);
    chk("rst_gnt", -1, 16'(gnt), 16'h0001);
    chk("rst_mv", -1, 16'(match_valid), 16'h0);
    chk("rst_mch", -1, 16'(match_ch), 16'h0);
    chk("rst_cnt", -1, match_cnt, 16'h0);
    req = '0;
    @(posedge clk);
    #1 reset = 1'b0;

    add(4'b1111, 4'b0, 4'b0, 4'b0001, 0, 0, 0);
    add(4'b1111, 4'b0, 4'b0, 4'b0010, 0, 0, 0);
    add(4'b1111, 4'b0, 4'b0, 4'b0100, 0, 0, 0);
    add(4'b1111, 4'b0, 4'b0, 4'b1000, 0, 0, 0);
    add(4'b1111, 4'b0, 4'b0, 4'b0001, 0, 0, 0);
    add(4'b1111, 4'b0, 4'b0, 4'b0010, 0, 0, 0);
    add(4'b1111, 4'b0, 4'b0, 4'b0100, 0, 0, 0);
    add(4'b1111, 4'b0, 4'b0, 4'b1000, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(4'b1010, 4'b0, 4'b0, (i % 2 == 0) ? 4'b0010 : 4'b1000, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(4'b0001, p6[5-i] ? 4'b0001 : 4'b0, 4'b0, 4'b0001, 0, 0, 0);
    add(4'b0000, 4'b0, 4'b0, 4'b0000, 1, 0, 1);
    for (int i = 0; i < 10; i++)
      add(4'b0100, p10[9-i] ? 4'b0100 : 4'b0, 4'b0, 4'b0100, i == 6, 2, (i < 6) ? 16'd1 : 16'd2);
    add(4'b0000, 4'b0, 4'b0, 4'b0000, 1, 2, 3);
    add(4'b0001, 4'b0, 4'b0, 4'b0001, 0, 0, 3);
    for (int i = 0; i < 12; i++)
      add(4'b1010, p6[5-i/2] ? 4'b1010 : 4'b0, 4'b0, (i % 2 == 0) ? 4'b0010 : 4'b1000,
          i == 11, 1, (i < 11) ? 16'd3 : 16'd4);
    add(4'b0000, 4'b0, 4'b0, 4'b0000, 1, 3, 5);
    add(4'b0000, 4'b0, 4'b0, 4'b0000, 0, 0, 5);
    for (int i = 0; i < 4; i++) add(4'b0001, p6[5-i] ? 4'b0001 : 4'b0, 4'b0, 4'b0001, 0, 0, 5);
    add(4'b0001, 4'b0001, 4'b0001, 4'b0001, 0, 0, 5);
    for (int i = 0; i < 6; i++)
      add(4'b0001, p6[5-i] ? 4'b0001 : 4'b0, (i == 2) ? 4'b0100 : 4'b0, 4'b0001, 0, 0, 5);
    add(4'b0000, 4'b0, 4'b0, 4'b0000, 1, 0, 6);
    add(4'b0000, 4'b0, 4'b0, 4'b0000, 0, 0, 6);

    foreach (vecs[r]) begin
      @(posedge clk);
      #1;
      req = vecs[r].req;
      bit_in = vecs[r].bit_in;
      clr = vecs[r].clr;
      @(negedge clk);
      chk("gnt", r, 16'(gnt), 16'(vecs[r].gnt));
      chk("match_valid", r, 16'(match_valid), 16'(vecs[r].mv));
      if (vecs[r].mv) chk("match_ch", r, 16'(match_ch), 16'(vecs[r].mch));
      chk("match_cnt", r, match_cnt, vecs[r].cnt);
    end

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      req = 4'b0001;
      bit_in = p6[5-i] ? 4'b0001 : 4'b0;
      clr = '0;
    end
    @(posedge clk);
    #1;
    req = '0;
    bit_in = '0;
    #2 reset = 1'b1;
    req = 4'b1111;
    #1;
    chk("mid_rst_gnt", -2, 16'(gnt), 16'h0001);
    chk("mid_rst_mv", -2, 16'(match_valid), 16'h0);
    chk("mid_rst_cnt", -2, match_cnt, 16'h0);
    req = '0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    req = 4'b1111;
    bit_in = 4'b0001;
    @(negedge clk);
    chk("post_rst_gnt", -3, 16'(gnt), 16'h0001);
    @(posedge clk);
    #1;
    req = '0;
    bit_in = '0;
    @(negedge clk);
    chk("post_rst_mv", -3, 16'(match_valid), 16'h0);
    chk("post_rst_cnt", -3, match_cnt, 16'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/seq_det_arbiter.md
# seq_det_arbiter

Time-multiplexed serial pattern detector shared among `N_CH` bit-serial requesters. A round-robin arbiter grants one requester per cycle. The granted bit is shifted into that channel's private history register, and the shifted value is compared against a single fixed pattern. The block sits between the serial input sources and the match-event consumer, replacing one detector per stream with one shared comparator.

## Interface
- `N_CH`, 4: number of requesters, 2..8.
- `PAT_W`, 6: pattern and history width in bits.
- `PATTERN`, 6'b110011: pattern to detect. MSB is the oldest bit.
- `CH_W`, $clog2(N_CH): channel index width (derived).

Ports. Reset is `reset`, asynchronous, active-high; clock is `clk`.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous active-high reset.
- `req`  in  N_CH: per-channel "bit available" request.
- `bit_in`  in  N_CH: per-channel serial data bit. Valid when the matching `req` bit is high.
- `clr`  in  N_CH: per-channel synchronous history clear.
- `gnt`  out  N_CH: one-hot grant, combinational. The channel's bit is consumed at the edge where `gnt[c]`=1.
- `match_valid`  out  1: registered one-cycle pulse; a match occurred on the previous grant.
- `match_ch`  out  CH_W: channel index of the match. Valid while `match_valid`=1.
- `match_cnt`  out  16: total matches across all channels, saturating at 16'hFFFF.

## Operation
- Per-channel state:
  - `hist[c]` (PAT_W bits): newest bit in the LSB.
  - `fill[c]` (0..PAT_W): number of valid bits, saturating at PAT_W.
- Arbiter:
  - Pointer `ptr` (CH_W bits).
  - Grant goes to the first channel with `req` high, searching `ptr`, `ptr`+1, … modulo N_CH.
  - After a grant to channel k, `ptr` becomes (k+1) mod N_CH.
  - With no requests there is no grant and `ptr` holds.
- On a grant to channel k, with no clear on k:
  - `hist[k]` ← {hist[k][PAT_W-2:0], bit_in[k]}.
  - `fill[k]` ← min(fill[k]+1, PAT_W).
  - A hit is declared when the new history equals PATTERN and the new fill equals PAT_W.
- Overlap:
  - Overlapping matches are allowed; history is not cleared on a hit.
  - With the default pattern, the stream 1100110011 gives two hits.
- Clear:
  - `clr[c]` sets `hist[c]`=0 and `fill[c]`=0 at the edge.
  - If `clr[k]` and `gnt[k]` occur in the same cycle, the clear wins. The bit is consumed (grant still issued, `ptr` advances), then discarded, and no hit is declared.
  - A clear on a non-granted channel does not affect the granted channel.
- Hit handling:
  - `match_valid`/`match_ch` are registered from the hit.
  - `match_cnt` increments on each hit and holds at 16'hFFFF.
- Reset values:
  - All `hist`=0, all `fill`=0, `ptr`=0.
  - `match_valid`=0, `match_ch`=0, `match_cnt`=0.
  - `gnt` follows `req` combinationally from `ptr`=0.

## Timing
- Grant is zero latency: `gnt` is a function of `req` and `ptr` in the same cycle. Requesters must hold `bit_in` stable while `req` is high.
- One bit is accepted per cycle, block-wide.
- Hit to output latency is 1 cycle: `match_valid` is high in the cycle after the edge that consumed the pattern's final bit.
- Back-to-back hits on different channels in consecutive cycles give consecutive `match_valid` pulses, each with its own `match_ch`.
- Reset mid-sequence discards all partial histories. No match can complete using pre-reset bits.

## Structure
- The shared package holds the default PATTERN, PAT_W and N_CH constants, and the match-counter width (16).
- One natural sub-module: `rr_arbiter`.
  - Parameter: N_CH.
  - Ports: `clk`, `reset`, `req`, `gnt`.
  - Owns `ptr`.
- The top level owns the history and fill bank, the comparator, and the output registers.

## Test plan
- **Single channel match.** Only channel 0 requests, `bit_in` sequence 1,1,0,0,1,1.
  - `gnt`=4'b0001 every cycle.
  - `match_valid`=1 with `match_ch`=0 in the cycle after the 6th bit; `match_cnt`=1.
- **Overlap.** Channel 2 sends 1,1,0,0,1,1,0,0,1,1.
  - Pulses after bit 6 and bit 10, `match_ch`=2 both times; `match_cnt`=2.
- **Round-robin order.** `req`=4'b1111 held for 5 cycles.
  - `gnt` sequence: 0001, 0010, 0100, 1000, 0001.
  - With `req`=4'b1010 from `ptr`=0, `gnt` alternates 0010, 1000.
- **Interleaved streams.** Channels 1 and 3 both send 110011, interleaved by the arbiter.
  - Two pulses in consecutive cycles: `match_ch`=1, then `match_ch`=3.
- **Clear collision.** Channel 0 sends 1,1,0,0, then `clr[0]` asserted together with a granted 1, then 1,1,0,0,1,1.
  - No hit before the final six bits.
  - Exactly one hit after the last bit.
- **Reset mid-operation.** Channel 0 sends 1,1,0,0,1; assert `reset` between edges; release; send 1.
  - No `match_valid`; `match_cnt`=0.
  - Next `gnt` with `req`=4'b1111 is 0001.
